// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with byte/half/word access, registered response and a post-reset zero sweep.
// Optional DMEM_TRACE_EN: simulation-only trace of accepted stores and faulting requests.
module dmem_bytelane #(
    parameter int ADDR_W         = 12,
    parameter int DEPTH_WORDS    = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);
    localparam int PTR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t            state, state_next;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-3:0] word_idx;
    logic [PTR_W-1:0]  mem_idx;
    logic              accept;
    logic              fault;
    logic              out_of_range;
    logic [3:0]        byte_en;
    logic [31:0]       lane_data;
    logic [31:0]       rd_word;
    logic [31:0]       shifted;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign word_idx = req_addr[ADDR_W-1:2];
    assign mem_idx  = word_idx[PTR_W-1:0];
    assign rd_word  = mem[mem_idx];
    assign accept   = req_valid & ready;

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        ready      = 1'b0;
        case (state)
            ST_CLEAR: begin
                ptr_next = ptr + PTR_W'(1);
                if (ptr == PTR_W'(DEPTH_WORDS - 1)) begin
                    state_next = ST_READY;
                    ptr_next   = '0;
                end
            end
            ST_READY: ready = 1'b1;
            default:  state_next = ST_READY;
        endcase
    end

    // Lane decode, fault checks and load extraction all work off the same async word read.
    always_comb begin
        out_of_range = (32'(word_idx) >= 32'(DEPTH_WORDS));
        fault        = 1'b0;
        byte_en      = 4'b0000;
        lane_data    = req_wdata;
        shifted      = rd_word >> {req_addr[1:0], 3'b000};
        load_data    = rd_word;
        case (req_size)
            2'b00: begin
                byte_en   = 4'b0001 << req_addr[1:0];
                lane_data = {4{req_wdata[7:0]}};
                load_data = req_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
            end
            2'b01: begin
                fault     = req_addr[0];
                byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{req_wdata[15:0]}};
                load_data = req_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
            end
            2'b10: begin
                fault   = |req_addr[1:0];
                byte_en = 4'b1111;
            end
            default: fault = 1'b1;
        endcase
        fault  = fault | out_of_range;
        merged = rd_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[ptr] <= '0;
        end else if (accept && req_we && !fault) begin
            mem[mem_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            rsp_valid <= accept;
            rsp_fault <= accept & fault;
            rsp_rdata <= (accept && !req_we && !fault) ? load_data : '0;
        end
    end

`ifdef DMEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (accept && fault) begin
            $display("DMEM FAULT addr=%h size=%b", req_addr, req_size);
        end else if (accept && req_we) begin
            $display("DMEM STORE addr=%h size=%b wdata=%h word=%h", req_addr, req_size, req_wdata, merged);
        end
    end
`else
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane with DEPTH_WORDS = 16: sweep timing, extension, lane merging, faults, reset.
module tb_dmem_bytelane;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [33:0] rsp;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_bytelane #(
        .ADDR_W         (12),
        .DEPTH_WORDS    (16),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ready      (ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault)
    );

    assign rsp = {rsp_valid, rsp_fault, rsp_rdata};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [11:0] addr, input logic [31:0] wdata);
        req_valid  = v;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic test_reset();
        int cnt;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        step();
        step();
        tests_run++;
        if ({ready, rsp} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready/rsp %h, expected 0", {ready, rsp});
        end
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < 100) begin
            step();
            cnt++;
        end
        tests_run++;
        if (cnt !== 16) begin
            tests_failed++;
            $display("FAIL sweep_cycles: got %0d, expected 16", cnt);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 2'b10, 1'b0, 12'(i * 4), 32'h0);
            step();
            tests_run++;
            if (rsp !== {1'b1, 1'b0, 32'h0}) begin
                tests_failed++;
                $display("FAIL load_zero @%h: got %h, expected %h", 12'(i * 4), rsp, {1'b1, 1'b0, 32'h0});
            end
        end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        step();
        tests_run++;
        if (rsp !== 34'h0) begin
            tests_failed++;
            $display("FAIL idle_rsp: got %h, expected 0", rsp);
        end
    endtask

    task automatic test_extension();
        logic [11:0] addrs [8] = '{12'h011, 12'h013, 12'h012, 12'h010, 12'h013, 12'h012, 12'h010, 12'h010};
        logic [1:0]  sizes [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
        logic        sgns  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exps  [8] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'h00007F01,
                                   32'h00000080, 32'hFFFF80FF, 32'h80FF7F01, 32'h00000001};
        drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF7F01);
        step();
        tests_run++;
        if (rsp !== {1'b1, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL store_ack: got %h, expected %h", rsp, {1'b1, 1'b0, 32'h0});
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, sizes[i], sgns[i], addrs[i], 32'hFFFFFFFF);
            step();
            tests_run++;
            if (rsp !== {1'b1, 1'b0, exps[i]}) begin
                tests_failed++;
                $display("FAIL ext_load[%0d] @%h: got %h, expected %h", i, addrs[i], rsp, {1'b1, 1'b0, exps[i]});
            end
        end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h014, 32'h11223344);
        step();
        drive(1'b1, 1'b1, 2'b00, 1'b0, 12'h016, 32'h123456AA);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h014, 32'h0);
        step();
        tests_run++;
        if (rsp !== {1'b1, 1'b0, 32'h11AA3344}) begin
            tests_failed++;
            $display("FAIL byte_merge: got %h, expected %h", rsp, {1'b1, 1'b0, 32'h11AA3344});
        end
        drive(1'b1, 1'b1, 2'b01, 1'b0, 12'h016, 32'hDEADBEEF);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b1, 12'h014, 32'h0);
        step();
        tests_run++;
        if (rsp !== {1'b1, 1'b0, 32'hBEEF3344}) begin
            tests_failed++;
            $display("FAIL half_merge: got %h, expected %h", rsp, {1'b1, 1'b0, 32'hBEEF3344});
        end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 12'h014, 32'h0);
        step();
        tests_run++;
        if (rsp !== 34'h0) begin
            tests_failed++;
            $display("FAIL b2b_idle: got %h, expected 0", rsp);
        end
    endtask

    task automatic test_faults();
        logic        wes   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0]  sizes [6] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01};
        logic [11:0] addrs [6] = '{12'h021, 12'h022, 12'h020, 12'h040, 12'h043, 12'h023};
        drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h020, 32'h55667788);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFEE);
            step();
            tests_run++;
            if (rsp !== {1'b1, 1'b1, 32'h0}) begin
                tests_failed++;
                $display("FAIL fault[%0d] @%h: got %h, expected %h", i, addrs[i], rsp, {1'b1, 1'b1, 32'h0});
            end
        end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
        step();
        tests_run++;
        if (rsp !== {1'b1, 1'b0, 32'h55667788}) begin
            tests_failed++;
            $display("FAIL fault_nowrite @020: got %h, expected %h", rsp, {1'b1, 1'b0, 32'h55667788});
        end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        step();
        tests_run++;
        if (rsp !== {1'b1, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL fault_nowrap @000: got %h, expected %h", rsp, {1'b1, 1'b0, 32'h0});
        end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        step();
    endtask

    task automatic test_reset_mid();
        int cnt;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_sweep_ready: got %b, expected 0", ready);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ready, rsp_valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset_sweep: got %b, expected 00", {ready, rsp_valid});
        end
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h010, 32'hCAFEF00D);
        cnt = 0;
        while (!ready && cnt < 100) begin
            step();
            cnt++;
            tests_run++;
            if (rsp !== 34'h0) begin
                tests_failed++;
                $display("FAIL dropped_req cycle %0d: got %h, expected 0", cnt, rsp);
            end
        end
        drive(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        tests_run++;
        if (cnt !== 16) begin
            tests_failed++;
            $display("FAIL resweep_cycles: got %0d, expected 16", cnt);
        end
        drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        step();
        tests_run++;
        if (rsp !== {1'b1, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL resweep_cleared @010: got %h, expected %h", rsp, {1'b1, 1'b0, 32'h0});
        end
        drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h018, 32'h12345678);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h018, 32'h0);
        @(posedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({ready, rsp} !== 35'h0) begin
                tests_failed++;
                $display("FAIL lost_load cycle %0d: got %h, expected 0", i, {ready, rsp});
            end
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < 100) begin
            step();
            cnt++;
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_lost_rsp cycle %0d: got %b, expected 0", cnt, rsp_valid);
            end
        end
        tests_run++;
        if (cnt !== 16) begin
            tests_failed++;
            $display("FAIL resweep2_cycles: got %0d, expected 16", cnt);
        end
        step();
        tests_run++;
        if (rsp !== 34'h0) begin
            tests_failed++;
            $display("FAIL final_idle: got %h, expected 0", rsp);
        end
    endtask

    initial begin
        test_reset();
        test_extension();
        test_back_to_back();
        test_faults();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
